// File: rtl/cr16_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cr16_pkg
// Description : Shared types and encodings for the CR16 control FSM:
//               controller states, instruction classes, regfile write
//               sources and the opcode/ext field values used by the decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package cr16_pkg;

  typedef enum logic [2:0] {
    S_RESET     = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEM       = 3'd4,
    S_PC_UPDATE = 3'd5,
    S_HALTED    = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    CLS_ALU   = 3'd0,
    CLS_LOAD  = 3'd1,
    CLS_STOR  = 3'd2,
    CLS_JAL   = 3'd3,
    CLS_JCOND = 3'd4,
    CLS_BCOND = 3'd5
  } iclass_e;

  typedef enum logic [1:0] {
    WSRC_ALU  = 2'd0,
    WSRC_MEM  = 2'd1,
    WSRC_LINK = 2'd2,
    WSRC_RSVD = 2'd3
  } wsrc_e;

  localparam logic [3:0] OP_LOADSTOR = 4'b0100;
  localparam logic [3:0] OP_BCOND    = 4'b1100;
  localparam logic [3:0] OP_REGREG   = 4'b0000;
  localparam logic [3:0] OP_CMPI     = 4'b1011;

  localparam logic [3:0] EXT_LOAD    = 4'b0000;
  localparam logic [3:0] EXT_STOR    = 4'b0100;
  localparam logic [3:0] EXT_JAL     = 4'b1000;
  localparam logic [3:0] EXT_JCOND   = 4'b1100;
  localparam logic [3:0] EXT_CMP     = 4'b1011;

endpackage
`default_nettype wire

// File: rtl/cr16_instr_classifier.sv
`default_nettype none
// ============================================================================
// Module      : cr16_instr_classifier
// Description : Combinational decode of the IR word into an instruction class
//               plus a flag marking ALU instructions that only set flags.
// Ports       : I_INSTRUCTION  - IR output word
//               O_CLASS        - instruction class
//               O_NO_WRITEBACK - CMP/CMPI: flags only, no Rdest write
// Revision    : 1.0 - initial release
// ============================================================================
module cr16_instr_classifier
  import cr16_pkg::*;
#(
  parameter int P_INSTRUCTION_WIDTH = 16
) (
  input  logic [P_INSTRUCTION_WIDTH-1:0] I_INSTRUCTION,
  output iclass_e                        O_CLASS,
  output logic                           O_NO_WRITEBACK
);

  logic [3:0] w_opcode;
  logic [3:0] w_ext;
  logic       w_unused_fields;

  assign w_opcode = I_INSTRUCTION[15:12];
  assign w_ext    = I_INSTRUCTION[7:4];
  // Register/cond fields play no part in classification.
  assign w_unused_fields = ^{I_INSTRUCTION[11:8], I_INSTRUCTION[3:0]};

  always_comb begin
    O_CLASS        = CLS_ALU;
    O_NO_WRITEBACK = 1'b0;
    if (w_opcode == OP_LOADSTOR) begin
      case (w_ext)
        EXT_LOAD:  O_CLASS = CLS_LOAD;
        EXT_STOR:  O_CLASS = CLS_STOR;
        EXT_JAL:   O_CLASS = CLS_JAL;
        EXT_JCOND: O_CLASS = CLS_JCOND;
        default:   O_CLASS = CLS_ALU;
      endcase
    end else if (w_opcode == OP_BCOND) begin
      O_CLASS = CLS_BCOND;
    end
    if ((w_opcode == OP_REGREG && w_ext == EXT_CMP) || w_opcode == OP_CMPI) begin
      O_NO_WRITEBACK = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cr16_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : cr16_control_fsm
// Description : Multi-cycle CR16 sequencer: fetch, decode, execute, memory
//               access and PC update. Sole driver of the pc block controls.
// Ports       : I_CLK, I_RESET (sync, active high); I_INSTRUCTION (IR out);
//               I_MEM_READY, I_COND_TRUE, I_HALT;
//               O_PC_* pc controls; O_MEM_* memory strobes/address mux;
//               O_IR_ENABLE; O_REGFILE_*; O_FLAGS_ENABLE; O_HALTED;
//               O_RETIRED_COUNT (only with CR16_CONTROL_FSM_RETIRE_COUNTER_EN).
// Option      : CR16_CONTROL_FSM_RETIRE_COUNTER_EN adds a 32-bit wrapping
//               count of PC-update cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module cr16_control_fsm
  import cr16_pkg::*;
#(
  parameter int P_INSTRUCTION_WIDTH = 16
) (
  input  logic                           I_CLK,
  input  logic                           I_RESET,
  input  logic [P_INSTRUCTION_WIDTH-1:0] I_INSTRUCTION,
  input  logic                           I_MEM_READY,
  input  logic                           I_COND_TRUE,
  input  logic                           I_HALT,
  output logic                           O_PC_ENABLE,
  output logic                           O_PC_NRESET,
  output logic                           O_PC_ADDRESS_SELECT,
  output logic                           O_PC_ADDRESS_SELECT_INCREMENT,
  output logic                           O_PC_ADDRESS_SOURCE,
  output logic                           O_MEM_ADDRESS_SOURCE,
  output logic                           O_MEM_READ,
  output logic                           O_MEM_WRITE,
  output logic                           O_IR_ENABLE,
  output logic                           O_REGFILE_WRITE_ENABLE,
  output logic [1:0]                     O_REGFILE_WRITE_SOURCE,
  output logic                           O_FLAGS_ENABLE,
  output logic                           O_HALTED
`ifdef CR16_CONTROL_FSM_RETIRE_COUNTER_EN
  ,
  output logic [31:0]                    O_RETIRED_COUNT
`endif
);

  state_e  state_q, state_d;
  logic    taken_q, taken_d;
  iclass_e w_class;
  logic    w_no_wb;

  // The IR is only loaded in S_FETCH, so its class is stable for the rest
  // of the instruction and can be decoded combinationally every cycle.
  cr16_instr_classifier #(
    .P_INSTRUCTION_WIDTH(P_INSTRUCTION_WIDTH)
  ) u_classifier (
    .I_INSTRUCTION (I_INSTRUCTION),
    .O_CLASS       (w_class),
    .O_NO_WRITEBACK(w_no_wb)
  );

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      state_q <= S_RESET;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      taken_q <= taken_d;
    end
  end

  always_comb begin
    state_d                       = state_q;
    taken_d                       = taken_q;
    O_PC_ENABLE                   = 1'b0;
    O_PC_NRESET                   = 1'b1;
    O_PC_ADDRESS_SELECT           = 1'b0;
    O_PC_ADDRESS_SELECT_INCREMENT = 1'b0;
    O_PC_ADDRESS_SOURCE           = 1'b0;
    O_MEM_ADDRESS_SOURCE          = 1'b0;
    O_MEM_READ                    = 1'b0;
    O_MEM_WRITE                   = 1'b0;
    O_IR_ENABLE                   = 1'b0;
    O_REGFILE_WRITE_ENABLE        = 1'b0;
    O_REGFILE_WRITE_SOURCE        = WSRC_ALU;
    O_FLAGS_ENABLE                = 1'b0;
    O_HALTED                      = 1'b0;

    case (state_q)
      S_RESET: begin
        // Enable held high with nreset low: the pc sees one rising enable.
        O_PC_ENABLE = 1'b1;
        O_PC_NRESET = 1'b0;
        state_d     = S_FETCH;
      end
      S_FETCH: begin
        O_MEM_READ  = 1'b1;
        O_IR_ENABLE = I_MEM_READY;
        if (I_MEM_READY) state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        state_d = S_PC_UPDATE;
        case (w_class)
          CLS_LOAD, CLS_STOR: state_d = S_MEM;
          CLS_JAL: begin
            O_REGFILE_WRITE_ENABLE = 1'b1;
            O_REGFILE_WRITE_SOURCE = WSRC_LINK;
          end
          CLS_JCOND, CLS_BCOND: taken_d = I_COND_TRUE;
          default: begin
            O_FLAGS_ENABLE         = 1'b1;
            O_REGFILE_WRITE_ENABLE = !w_no_wb;
          end
        endcase
      end
      S_MEM: begin
        O_MEM_ADDRESS_SOURCE = 1'b1;
        if (w_class == CLS_LOAD) begin
          O_MEM_READ = 1'b1;
          if (I_MEM_READY) begin
            O_REGFILE_WRITE_ENABLE = 1'b1;
            O_REGFILE_WRITE_SOURCE = WSRC_MEM;
          end
        end else begin
          O_MEM_WRITE = 1'b1;
        end
        if (I_MEM_READY) state_d = S_PC_UPDATE;
      end
      S_PC_UPDATE: begin
        O_PC_ENABLE = 1'b1;
        case (w_class)
          CLS_JAL: O_PC_ADDRESS_SELECT = 1'b1;
          CLS_JCOND: O_PC_ADDRESS_SELECT = taken_q;
          CLS_BCOND: begin
            O_PC_ADDRESS_SELECT = taken_q;
            O_PC_ADDRESS_SOURCE = taken_q;
          end
          default: O_PC_ADDRESS_SELECT = 1'b0;
        endcase
        state_d = I_HALT ? S_HALTED : S_FETCH;
      end
      S_HALTED: begin
        O_HALTED = 1'b1;
        if (!I_HALT) state_d = S_FETCH;
      end
      default: state_d = S_RESET;
    endcase
  end

`ifdef CR16_CONTROL_FSM_RETIRE_COUNTER_EN
  logic [31:0] retired_q;

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      retired_q <= '0;
    end else if (state_q == S_PC_UPDATE) begin
      retired_q <= retired_q + 32'd1;
    end
  end

  assign O_RETIRED_COUNT = retired_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cr16_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_cr16_control_fsm
// Description : Self-checking bench for cr16_control_fsm: a directed
//               cycle table followed by randomized instruction streams.
//               Honours CR16_CONTROL_FSM_RETIRE_COUNTER_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cr16_control_fsm;

  // Packed view of all control outputs:
  // {pc_en, nrst, sel, inc, psrc, msrc, mrd, mwr, ir, we, wsrc[1:0], flags, halted}
  localparam logic [13:0] B_PCEN    = 14'h2000;
  localparam logic [13:0] B_NRST    = 14'h1000;
  localparam logic [13:0] B_SEL     = 14'h0800;
  localparam logic [13:0] B_PSRC    = 14'h0200;
  localparam logic [13:0] B_MSRC    = 14'h0100;
  localparam logic [13:0] B_MRD     = 14'h0080;
  localparam logic [13:0] B_MWR     = 14'h0040;
  localparam logic [13:0] B_IR      = 14'h0020;
  localparam logic [13:0] B_WE      = 14'h0010;
  localparam logic [13:0] B_WS_LINK = 14'h0008;
  localparam logic [13:0] B_WS_MEM  = 14'h0004;
  localparam logic [13:0] B_FLG     = 14'h0002;
  localparam logic [13:0] B_HLT     = 14'h0001;

  localparam logic [13:0] E_RST    = B_PCEN;
  localparam logic [13:0] E_IDLE   = B_NRST;
  localparam logic [13:0] E_FWAIT  = B_NRST | B_MRD;
  localparam logic [13:0] E_FETCH  = B_NRST | B_MRD | B_IR;
  localparam logic [13:0] E_ALU    = B_NRST | B_FLG | B_WE;
  localparam logic [13:0] E_CMP    = B_NRST | B_FLG;
  localparam logic [13:0] E_JAL    = B_NRST | B_WE | B_WS_LINK;
  localparam logic [13:0] E_PC_INC = B_NRST | B_PCEN;
  localparam logic [13:0] E_PC_REG = B_NRST | B_PCEN | B_SEL;
  localparam logic [13:0] E_PC_BR  = B_NRST | B_PCEN | B_SEL | B_PSRC;
  localparam logic [13:0] E_LDW    = B_NRST | B_MSRC | B_MRD;
  localparam logic [13:0] E_LDR    = B_NRST | B_MSRC | B_MRD | B_WE | B_WS_MEM;
  localparam logic [13:0] E_ST     = B_NRST | B_MSRC | B_MWR;
  localparam logic [13:0] E_HALT   = B_NRST | B_HLT;

  localparam int K_ALU = 0, K_LOAD = 1, K_STOR = 2, K_JAL = 3, K_JCOND = 4, K_BCOND = 5;

  logic        clk;
  logic        rst, ready, cond, halt;
  logic [15:0] instr;
  logic        pc_en, pc_nrst, pc_sel, pc_inc, pc_src, mem_src, mem_rd, mem_wr;
  logic        ir_en, rf_we, flags_en, halted;
  logic [1:0]  rf_src;
  logic [13:0] act;
`ifdef CR16_CONTROL_FSM_RETIRE_COUNTER_EN
  logic [31:0] retired;
  logic [31:0] exp_ret;
`endif

  int tests;
  int failed;

  typedef struct {
    logic        rst;
    logic [15:0] instr;
    logic        ready;
    logic        cond;
    logic        halt;
    logic [13:0] exp;
  } vec_t;

  vec_t vecs[$];

  cr16_control_fsm #(.P_INSTRUCTION_WIDTH(16)) dut (
    .I_CLK                        (clk),
    .I_RESET                      (rst),
    .I_INSTRUCTION                (instr),
    .I_MEM_READY                  (ready),
    .I_COND_TRUE                  (cond),
    .I_HALT                       (halt),
    .O_PC_ENABLE                  (pc_en),
    .O_PC_NRESET                  (pc_nrst),
    .O_PC_ADDRESS_SELECT          (pc_sel),
    .O_PC_ADDRESS_SELECT_INCREMENT(pc_inc),
    .O_PC_ADDRESS_SOURCE          (pc_src),
    .O_MEM_ADDRESS_SOURCE         (mem_src),
    .O_MEM_READ                   (mem_rd),
    .O_MEM_WRITE                  (mem_wr),
    .O_IR_ENABLE                  (ir_en),
    .O_REGFILE_WRITE_ENABLE       (rf_we),
    .O_REGFILE_WRITE_SOURCE       (rf_src),
    .O_FLAGS_ENABLE               (flags_en),
    .O_HALTED                     (halted)
`ifdef CR16_CONTROL_FSM_RETIRE_COUNTER_EN
    ,
    .O_RETIRED_COUNT              (retired)
`endif
  );

  assign act = {pc_en, pc_nrst, pc_sel, pc_inc, pc_src, mem_src, mem_rd, mem_wr,
                ir_en, rf_we, rf_src, flags_en, halted};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Instruction class straight from the encoding table.
  function automatic int class_of(input logic [15:0] w);
    if (w[15:12] == 4'b1100) return K_BCOND;
    if (w[15:12] == 4'b0100) begin
      if (w[7:4] == 4'b0000) return K_LOAD;
      if (w[7:4] == 4'b0100) return K_STOR;
      if (w[7:4] == 4'b1000) return K_JAL;
      if (w[7:4] == 4'b1100) return K_JCOND;
    end
    return K_ALU;
  endfunction

  function automatic bit is_cmp(input logic [15:0] w);
    return (w[15:12] == 4'b0000 && w[7:4] == 4'b1011) || w[15:12] == 4'b1011;
  endfunction

  // Drive one cycle of inputs, check outputs mid-cycle, advance past the edge.
  task automatic run_cycle(input string tag, input int idx, input logic rst_v,
                           input logic [15:0] ins, input logic rdy, input logic cnd,
                           input logic hlt, input logic [13:0] exp);
    rst   = rst_v;
    instr = ins;
    ready = rdy;
    cond  = cnd;
    halt  = hlt;
    #2;
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s[%0d] outputs: got %b required %b", tag, idx, act, exp);
    end
`ifdef CR16_CONTROL_FSM_RETIRE_COUNTER_EN
    tests++;
    if (retired !== exp_ret) begin
      failed++;
      $display("FAIL %s[%0d] retired_count: got %0d required %0d", tag, idx, retired, exp_ret);
    end
`endif
    @(posedge clk);
    #1;
`ifdef CR16_CONTROL_FSM_RETIRE_COUNTER_EN
    if (rst_v) exp_ret = 32'd0;
    else if ((exp & (B_PCEN | B_NRST)) == (B_PCEN | B_NRST)) exp_ret = exp_ret + 32'd1;
`endif
  endtask

  task automatic add(input logic r, input logic [15:0] w, input logic rdy,
                     input logic c, input logic h, input logic [13:0] e);
    vecs.push_back('{r, w, rdy, c, h, e});
  endtask

  // Zero-wait non-memory instruction: fetch, decode, execute, pc update.
  task automatic add_simple(input logic [15:0] w, input logic c_exec,
                            input logic [13:0] e_exec, input logic [13:0] e_pcu);
    add(0, w, 1, 0, 0, E_FETCH);
    add(0, w, 0, 0, 0, E_IDLE);
    add(0, w, 0, c_exec, 0, e_exec);
    add(0, w, 0, !c_exec, 0, e_pcu);
  endtask

  initial begin
    logic [15:0] w;
    int          k, fw, mw, hcnt;
    logic        c, h;
    logic [13:0] e;

    tests  = 0;
    failed = 0;
    rst = 1'b1; instr = 16'h0; ready = 1'b0; cond = 1'b0; halt = 1'b0;
`ifdef CR16_CONTROL_FSM_RETIRE_COUNTER_EN
    exp_ret = 32'd0;
`endif
    repeat (2) @(posedge clk);
    #1;

    // ---------------- directed cycle table ----------------
    add(1, 16'h0, 1, 0, 0, E_RST);
    add(1, 16'h0, 1, 0, 0, E_RST);
    add(1, 16'h0, 1, 0, 0, E_RST);
    add(0, 16'h0, 1, 0, 0, E_RST);           // first free cycle, still S_RESET
    add_simple(16'h0152, 0, E_ALU, E_PC_INC); // ADD R1,R2
    add(0, 16'h01B2, 0, 0, 0, E_FWAIT);       // CMP with one fetch wait
    add_simple(16'h01B2, 0, E_CMP, E_PC_INC);
    add(0, 16'h4304, 1, 0, 0, E_FETCH);       // LOAD R3,R4, two mem waits
    add(0, 16'h4304, 0, 0, 0, E_IDLE);
    add(0, 16'h4304, 1, 0, 0, E_IDLE);
    add(0, 16'h4304, 0, 0, 0, E_LDW);
    add(0, 16'h4304, 0, 0, 0, E_LDW);
    add(0, 16'h4304, 1, 0, 0, E_LDR);
    add(0, 16'h4304, 0, 0, 0, E_PC_INC);
    add_simple(16'hC005, 1, E_IDLE, E_PC_BR);  // BCOND taken
    add_simple(16'hC005, 0, E_IDLE, E_PC_INC); // BCOND not taken
    add_simple(16'h4687, 0, E_JAL, E_PC_REG);  // JAL R6,R7
    add_simple(16'h46C7, 1, E_IDLE, E_PC_REG); // JCOND taken
    add_simple(16'hB123, 0, E_CMP, E_PC_INC);  // CMPI
    add(0, 16'h4344, 1, 0, 0, E_FETCH);        // STOR, zero wait
    add(0, 16'h4344, 0, 0, 0, E_IDLE);
    add(0, 16'h4344, 0, 0, 0, E_IDLE);
    add(0, 16'h4344, 1, 0, 0, E_ST);
    add(0, 16'h4344, 0, 0, 0, E_PC_INC);
    add(0, 16'h4344, 1, 0, 0, E_FETCH);        // STOR, reset mid-access
    add(0, 16'h4344, 0, 0, 0, E_IDLE);
    add(0, 16'h4344, 0, 0, 0, E_IDLE);
    add(0, 16'h4344, 0, 0, 0, E_ST);
    add(1, 16'h4344, 0, 0, 0, E_ST);
    add(1, 16'h4344, 0, 0, 0, E_RST);
    add(0, 16'h4344, 0, 0, 0, E_RST);
    add(0, 16'h0152, 1, 0, 0, E_FETCH);        // ADD then halt
    add(0, 16'h0152, 0, 0, 0, E_IDLE);
    add(0, 16'h0152, 0, 0, 0, E_ALU);
    add(0, 16'h0152, 0, 0, 1, E_PC_INC);
    add(0, 16'h0152, 0, 0, 1, E_HALT);
    add(0, 16'h0152, 1, 1, 0, E_HALT);

    for (int i = 0; i < vecs.size(); i++) begin
      run_cycle("table", i, vecs[i].rst, vecs[i].instr, vecs[i].ready,
                vecs[i].cond, vecs[i].halt, vecs[i].exp);
    end

    // ---------------- randomized instruction stream ----------------
    for (int n = 0; n < 200; n++) begin
      w = 16'($urandom);
      case ($urandom_range(0, 9))
        5: w = {4'b0100, w[11:8], 4'b0000, w[3:0]};
        6: w = {4'b0100, w[11:8], 4'b0100, w[3:0]};
        7: w = {4'b0100, w[11:8], 4'b1000, w[3:0]};
        8: w = {4'b0100, w[11:8], 4'b1100, w[3:0]};
        9: w = {4'b1100, w[11:0]};
        default: ;
      endcase
      k    = class_of(w);
      fw   = $urandom_range(0, 2);
      mw   = $urandom_range(0, 2);
      c    = 1'($urandom_range(0, 1));
      h    = ($urandom_range(0, 7) == 0);
      hcnt = $urandom_range(0, 2);

      for (int j = 0; j < fw; j++)
        run_cycle("rand_fetch", n, 0, w, 0, 1'($urandom), 1'($urandom), E_FWAIT);
      run_cycle("rand_fetch", n, 0, w, 1, 1'($urandom), 1'($urandom), E_FETCH);
      run_cycle("rand_decode", n, 0, w, 1'($urandom), 1'($urandom), 1'($urandom), E_IDLE);

      if (k == K_ALU)      e = is_cmp(w) ? E_CMP : E_ALU;
      else if (k == K_JAL) e = E_JAL;
      else                 e = E_IDLE;
      run_cycle("rand_exec", n, 0, w, 1'($urandom), c, 1'($urandom), e);

      if (k == K_LOAD || k == K_STOR) begin
        for (int j = 0; j < mw; j++)
          run_cycle("rand_mem", n, 0, w, 0, 1'($urandom), 1'($urandom),
                    (k == K_LOAD) ? E_LDW : E_ST);
        run_cycle("rand_mem", n, 0, w, 1, 1'($urandom), 1'($urandom),
                  (k == K_LOAD) ? E_LDR : E_ST);
      end

      if (k == K_JAL || (k == K_JCOND && c)) e = E_PC_REG;
      else if (k == K_BCOND && c)            e = E_PC_BR;
      else                                   e = E_PC_INC;
      run_cycle("rand_pcu", n, 0, w, 1'($urandom), 1'($urandom), h, e);

      if (h) begin
        for (int j = 0; j < hcnt; j++)
          run_cycle("rand_halt", n, 0, w, 1'($urandom), 1'($urandom), 1, E_HALT);
        run_cycle("rand_halt", n, 0, w, 1'($urandom), 1'($urandom), 0, E_HALT);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
